vjtag_frame_parser: RTL and testbench
=====================================

Name: vjtag_frame_parser

Overview:
- Sits directly downstream of the virtual-JTAG DR interface, in the tck domain.
- Consumes the byte delivered on each Update-DR and assembles it into framed write commands: SYNC, ADDR, LEN, payload, checksum.
- Buffers the payload, verifies the checksum, then issues a burst of register writes.
- Returns an 8-bit status byte, fed back as the DR capture value (data_sent_to_pc).

Parameters:
- ADDR_W, 8, width of register address; burst addresses wrap modulo 2^ADDR_W.
- MAX_LEN, 16, maximum payload bytes per frame (1..255).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- tck  input  1  sole clock (JTAG TCK); all logic on rising edge.
- aclr  input  1  asynchronous active-high reset.
- byte_in  input  8  received byte, valid only with byte_valid.
- byte_valid  input  1  one-cycle strobe per received byte (driven from v_udr).
- abort  input  1  synchronous frame abort (IR change); level-sensitive.
- reg_wr_en  output  1  write strobe, one cycle per payload byte.
- reg_addr  output  ADDR_W  write address.
- reg_wr_data  output  8  write data.
- status  output  8  {busy, last_ok, err_cnt[5:0]}.
- frame_err  output  1  one-cycle pulse on any frame error.

Behaviour:
- Reset values (aclr high, asynchronous):
  - state=IDLE.
  - reg_wr_en=0, reg_addr=0, reg_wr_data=0.
  - status=8'h00, frame_err=0.
  - Buffer contents are don't-care.
- FSM states: IDLE, ADDR, LEN, DATA, CHK, DRAIN. Transitions occur only on byte_valid, except in DRAIN.
- IDLE:
  - byte==SYNC_BYTE -> ADDR.
  - Any other byte is ignored; no error.
- ADDR: latch base address (low ADDR_W bits of byte; upper bits ignored); chk=byte -> LEN.
- LEN:
  - If byte==0 or byte>MAX_LEN: frame_err pulse, err_cnt++ -> IDLE.
  - Otherwise: latch len, chk^=byte, idx=0 -> DATA.
- DATA: buf[idx]=byte, chk^=byte, idx++. When idx reaches len -> CHK.
- CHK:
  - If byte==chk: last_ok=1 -> DRAIN.
  - Else: last_ok=0, frame_err pulse, err_cnt++ -> IDLE. No writes are issued.
- DRAIN:
  - First reg_wr_en occurs the cycle after the checksum strobe.
  - Then exactly len consecutive cycles, with reg_addr=base+i (mod 2^ADDR_W) and reg_wr_data=buf[i], i=0..len-1.
  - After the last write -> IDLE; reg_wr_en=0.
  - A byte_valid during DRAIN is dropped (overrun): frame_err pulse, err_cnt++. The drain still completes.
- busy=1 in every state except IDLE.
- err_cnt saturates at 63. Only aclr clears it.
- abort:
  - Forces IDLE next cycle from any state, including DRAIN; remaining writes are cancelled.
  - Not counted as an error.
  - abort and byte_valid in the same cycle: abort wins and the byte is discarded.
- frame_err and err_cnt increment are simultaneous with the error-causing strobe, registered (visible the next cycle).
- aclr mid-frame or mid-drain: immediate IDLE and outputs return to their reset values.
- All outputs are registered.

Decomposition:
- Shared package vjtag_pkg:
  - state enum (IDLE..DRAIN).
  - SYNC_BYTE default.
  - status bit-position constants (BUSY_BIT=7, OK_BIT=6, ERR_LSB=0).
  - ERR_CNT_MAX=63.
- One sub-module, vjtag_frame_buf:
  - MAX_LEN x 8 register array.
  - Write port (we, waddr, wdata); asynchronous read port.
  - No reset on storage.

Test Plan:
- Good frame: bytes A5,10,02,11,22,21 -> two writes on consecutive cycles (0x10<=0x11, 0x11<=0x22); status=8'h40 after drain; no frame_err.
- Bad checksum: A5,10,02,11,22,20 -> no reg_wr_en; frame_err pulse; status=8'h01.
- Bad length: A5,05,00 then A5,05,11 (MAX_LEN=16) -> two errors; err_cnt=2; FSM back in IDLE; a subsequent valid frame is accepted.
- Address wrap: A5,FF,02,AA,BB,EC -> writes 0xFF<=0xAA, then 0x00<=0xBB.
- Abort and overrun:
  - abort after A5,10,03,01 -> IDLE; no writes; err_cnt unchanged.
  - MAX_LEN frame with a byte_valid injected during DRAIN -> all 16 writes complete; err_cnt+1.
- Saturation and reset: 70 bad-checksum frames -> err_cnt=63; aclr pulse mid-DATA -> status=0, and the next good frame writes correctly.

Source files
------------

// File: rtl/vjtag_pkg.sv
// Shared types and constants for the virtual-JTAG frame parser slice.
package vjtag_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      LEN   = 3'd2,
      DATA  = 3'd3,
      CHK   = 3'd4,
      DRAIN = 3'd5
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   localparam int BUSY_BIT    = 7;
   localparam int OK_BIT      = 6;
   localparam int ERR_LSB     = 0;
   localparam int ERR_W       = 6;
   localparam int ERR_CNT_MAX = 63;

endpackage

// File: rtl/vjtag_frame_parser_if.sv
// Byte stream from the DR chain and register-write bus leaving the parser.
interface vjtag_frame_parser_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              abort;
   logic              reg_wr_en;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_wr_data;

   // master = host/TAP side, slave = parser side
   modport master (
      output byte_in, byte_valid, abort,
      input  reg_wr_en, reg_addr, reg_wr_data
   );

   modport slave (
      input  byte_in, byte_valid, abort,
      output reg_wr_en, reg_addr, reg_wr_data
   );
endinterface

// File: rtl/vjtag_frame_buf.sv
// Payload buffer: DEPTH x 8 registers, synchronous write, asynchronous read.
module vjtag_frame_buf #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [7:0]       wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [7:0]       rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we && (32'(waddr) < DEPTH))
         mem[waddr] <= wdata;
   end

   // Non-power-of-two depths leave unused index codes; read them as zero.
   assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/vjtag_frame_parser.sv
// Assembles Update-DR bytes into checksummed write frames and replays them as a register-write burst.
module vjtag_frame_parser
   import vjtag_pkg::*;
#(
   parameter int         ADDR_W    = 8,
   parameter int         MAX_LEN   = 16,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic                 tck,
   input  logic                 aclr,
   vjtag_frame_parser_if.slave  bus,
   output logic [7:0]           status,
   output logic                 frame_err
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [7:0]        len;
   logic [7:0]        idx;
   logic [7:0]        wr_idx;
   logic [7:0]        chk;
   logic              busy;
   logic              last_ok;
   logic [ERR_W-1:0]  err_cnt;

   logic              strobe;
   logic              buf_we;
   logic [IDX_W-1:0]  buf_waddr;
   logic [IDX_W-1:0]  buf_raddr;
   logic [7:0]        buf_rdata;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
      return (c == ERR_W'(ERR_CNT_MAX)) ? c : c + 1'b1;
   endfunction

   // abort outranks a coincident byte, so the byte never reaches the FSM
   assign strobe    = bus.byte_valid & ~bus.abort;
   assign buf_we    = strobe && (state == DATA);
   assign buf_waddr = idx[IDX_W-1:0];
   assign buf_raddr = (state == DRAIN) ? wr_idx[IDX_W-1:0] : '0;

   vjtag_frame_buf #(
      .DEPTH (MAX_LEN),
      .IDX_W (IDX_W)
   ) u_buf (
      .clk   (tck),
      .we    (buf_we),
      .waddr (buf_waddr),
      .wdata (bus.byte_in),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );

   always_ff @(posedge tck or posedge aclr) begin
      if (aclr) begin
         state           <= IDLE;
         base            <= '0;
         len             <= '0;
         idx             <= '0;
         wr_idx          <= '0;
         chk             <= '0;
         busy            <= 1'b0;
         last_ok         <= 1'b0;
         err_cnt         <= '0;
         frame_err       <= 1'b0;
         bus.reg_wr_en   <= 1'b0;
         bus.reg_addr    <= '0;
         bus.reg_wr_data <= '0;
      end else begin
         frame_err <= 1'b0;
         if (bus.abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            bus.reg_wr_en <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (strobe && (bus.byte_in == SYNC_BYTE)) begin
                     state <= ADDR;
                     busy  <= 1'b1;
                  end
               end
               ADDR: begin
                  if (strobe) begin
                     base  <= ADDR_W'(bus.byte_in);
                     chk   <= bus.byte_in;
                     state <= LEN;
                  end
               end
               LEN: begin
                  if (strobe) begin
                     if ((bus.byte_in == 8'h00) || (bus.byte_in > 8'(MAX_LEN))) begin
                        frame_err <= 1'b1;
                        err_cnt   <= sat_inc(err_cnt);
                        state     <= IDLE;
                        busy      <= 1'b0;
                     end else begin
                        len   <= bus.byte_in;
                        chk   <= chk ^ bus.byte_in;
                        idx   <= '0;
                        state <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (strobe) begin
                     chk <= chk ^ bus.byte_in;
                     idx <= idx + 8'd1;
                     if ((idx + 8'd1) == len)
                        state <= CHK;
                  end
               end
               CHK: begin
                  if (strobe) begin
                     if (bus.byte_in == chk) begin
                        // First write is launched here so it lands the cycle after the strobe
                        last_ok         <= 1'b1;
                        state           <= DRAIN;
                        bus.reg_wr_en   <= 1'b1;
                        bus.reg_addr    <= base;
                        bus.reg_wr_data <= buf_rdata;
                        wr_idx          <= 8'd1;
                     end else begin
                        last_ok   <= 1'b0;
                        frame_err <= 1'b1;
                        err_cnt   <= sat_inc(err_cnt);
                        state     <= IDLE;
                        busy      <= 1'b0;
                     end
                  end
               end
               DRAIN: begin
                  if (strobe) begin
                     frame_err <= 1'b1;
                     err_cnt   <= sat_inc(err_cnt);
                  end
                  if (wr_idx == len) begin
                     bus.reg_wr_en <= 1'b0;
                     state         <= IDLE;
                     busy          <= 1'b0;
                  end else begin
                     bus.reg_wr_en   <= 1'b1;
                     bus.reg_addr    <= base + ADDR_W'(wr_idx);
                     bus.reg_wr_data <= buf_rdata;
                     wr_idx          <= wr_idx + 8'd1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      status                       = '0;
      status[BUSY_BIT]             = busy;
      status[OK_BIT]               = last_ok;
      status[ERR_LSB +: ERR_W]     = err_cnt;
   end

endmodule

// File: tb/tb_vjtag_frame_parser.sv
// Directed bench for vjtag_frame_parser: framing, checksum, burst writes, abort, overrun, saturation.
module tb_vjtag_frame_parser;
   import vjtag_pkg::*;

   logic       tck = 1'b0;
   logic       aclr;
   logic [7:0] status;
   logic       frame_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] wa_q[$];
   logic [7:0] wd_q[$];
   int         wc_q[$];
   int         err_pulses = 0;

   vjtag_frame_parser_if #(.ADDR_W(8)) bus ();

   vjtag_frame_parser #(
      .ADDR_W    (8),
      .MAX_LEN   (16),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .tck       (tck),
      .aclr      (aclr),
      .bus       (bus),
      .status    (status),
      .frame_err (frame_err)
   );

   always #5 tck = ~tck;

   always @(posedge tck) cyc <= cyc + 1;

   always @(negedge tck) begin
      if (!aclr) begin
         if (bus.reg_wr_en) begin
            wa_q.push_back(bus.reg_addr);
            wd_q.push_back(bus.reg_wr_data);
            wc_q.push_back(cyc);
         end
         if (frame_err) err_pulses++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge tck);
   endtask

   task automatic clear_mon();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      err_pulses = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge tck);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      @(negedge tck);
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_good_1010();
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
   endtask

   task automatic check_two_writes(input string name, input logic [7:0] a0, input logic [7:0] d0,
                                   input logic [7:0] a1, input logic [7:0] d1);
      checks++;
      if (wa_q.size() !== 2) begin
         errors++;
         $display("FAIL %s write_count: got %0d expected 2", name, wa_q.size());
      end else begin
         checks++;
         if (wa_q[0] !== a0 || wd_q[0] !== d0 || wa_q[1] !== a1 || wd_q[1] !== d1) begin
            errors++;
            $display("FAIL %s writes: got %h<=%h,%h<=%h expected %h<=%h,%h<=%h",
                     name, wa_q[0], wd_q[0], wa_q[1], wd_q[1], a0, d0, a1, d1);
         end
         checks++;
         if (wc_q[1] !== wc_q[0] + 1) begin
            errors++;
            $display("FAIL %s consecutive: cycles %0d,%0d", name, wc_q[0], wc_q[1]);
         end
      end
   endtask

   task automatic check_status(input string name, input logic [7:0] exp);
      checks++;
      if (status !== exp) begin
         errors++;
         $display("FAIL %s status: got %h expected %h", name, status, exp);
      end
   endtask

   task automatic check_errs(input string name, input int exp);
      checks++;
      if (err_pulses !== exp) begin
         errors++;
         $display("FAIL %s frame_err_pulses: got %0d expected %0d", name, err_pulses, exp);
      end
   endtask

   task automatic check_nowrites(input string name);
      checks++;
      if (wa_q.size() !== 0) begin
         errors++;
         $display("FAIL %s write_count: got %0d expected 0", name, wa_q.size());
      end
   endtask

   task automatic test_reset();
      aclr = 1'b1;
      bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.abort = 1'b0;
      idle(3);
      checks++;
      if (bus.reg_wr_en !== 1'b0 || bus.reg_addr !== 8'h00 || bus.reg_wr_data !== 8'h00 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%b addr=%h data=%h ferr=%b expected 0,00,00,0",
                  bus.reg_wr_en, bus.reg_addr, bus.reg_wr_data, frame_err);
      end
      check_status("reset", 8'h00);
      aclr = 1'b0;
      idle(2);
   endtask

   task automatic test_good_frame();
      clear_mon();
      send_good_1010();
      idle(4);
      check_two_writes("good", 8'h10, 8'h11, 8'h11, 8'h22);
      check_status("good", 8'h40);
      check_errs("good", 0);
   endtask

   task automatic test_bad_checksum();
      clear_mon();
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h20);
      idle(4);
      check_nowrites("badchk");
      check_errs("badchk", 1);
      check_status("badchk", 8'h01);
   endtask

   task automatic test_bad_length();
      clear_mon();
      send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
      send_byte(8'hA5); send_byte(8'h05); send_byte(8'h11);
      idle(3);
      check_errs("badlen", 2);
      check_status("badlen", 8'h03);
      send_byte(8'hA5); send_byte(8'h20); send_byte(8'h01);
      send_byte(8'h55); send_byte(8'h74);
      idle(4);
      checks++;
      if (wa_q.size() !== 1 || wa_q[0] !== 8'h20 || wd_q[0] !== 8'h55) begin
         errors++;
         $display("FAIL badlen_recover: got %0d writes first %h<=%h expected 1 write 20<=55",
                  wa_q.size(), wa_q.size() > 0 ? wa_q[0] : 8'hxx, wd_q.size() > 0 ? wd_q[0] : 8'hxx);
      end
      check_status("badlen_recover", 8'h43);
   endtask

   task automatic test_addr_wrap();
      clear_mon();
      send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h02);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hEC);
      idle(4);
      check_two_writes("wrap", 8'hFF, 8'hAA, 8'h00, 8'hBB);
      check_status("wrap", 8'h43);
   endtask

   task automatic test_abort();
      clear_mon();
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h01);
      check_status("abort_busy", 8'hC3);
      // abort with a coincident SYNC byte: the byte must be discarded
      @(negedge tck);
      bus.abort = 1'b1; bus.byte_valid = 1'b1; bus.byte_in = 8'hA5;
      @(negedge tck);
      bus.abort = 1'b0; bus.byte_valid = 1'b0;
      check_status("abort_idle", 8'h43);
      send_byte(8'h40); send_byte(8'h01); send_byte(8'h77); send_byte(8'h36);
      idle(4);
      check_nowrites("abort");
      check_errs("abort", 0);
      check_status("abort_end", 8'h43);
   endtask

   task automatic test_overrun();
      logic [7:0] c;
      clear_mon();
      c = 8'h30 ^ 8'h10;
      send_byte(8'hA5); send_byte(8'h30); send_byte(8'h10);
      for (int i = 0; i < 16; i++) begin
         send_byte(8'h80 + 8'(i));
         c = c ^ (8'h80 + 8'(i));
      end
      send_byte(c);
      send_byte(8'h5A);
      idle(20);
      checks++;
      if (wa_q.size() !== 16) begin
         errors++;
         $display("FAIL overrun write_count: got %0d expected 16", wa_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (wa_q[i] !== 8'h30 + 8'(i) || wd_q[i] !== 8'h80 + 8'(i) || wc_q[i] !== wc_q[0] + i) begin
               errors++;
               $display("FAIL overrun write%0d: got %h<=%h @%0d expected %h<=%h @%0d", i,
                        wa_q[i], wd_q[i], wc_q[i], 8'h30 + 8'(i), 8'h80 + 8'(i), wc_q[0] + i);
            end
         end
      end
      check_errs("overrun", 1);
      check_status("overrun", 8'h44);
   endtask

   task automatic test_saturation_and_reset();
      clear_mon();
      for (int f = 0; f < 70; f++) begin
         send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01);
         send_byte(8'h33); send_byte(8'h00);
      end
      idle(3);
      check_errs("sat", 70);
      check_status("sat", 8'h3F);
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h01);
      @(negedge tck);
      #2 aclr = 1'b1;
      #1;
      check_status("aclr_mid", 8'h00);
      checks++;
      if (bus.reg_wr_en !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL aclr_mid outputs: got en=%b ferr=%b expected 0,0", bus.reg_wr_en, frame_err);
      end
      @(negedge tck);
      aclr = 1'b0;
      idle(1);
      clear_mon();
      send_good_1010();
      idle(4);
      check_two_writes("post_aclr", 8'h10, 8'h11, 8'h11, 8'h22);
      check_status("post_aclr", 8'h40);
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_bad_length();
      test_addr_wrap();
      test_abort();
      test_overrun();
      test_saturation_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
